// File: rtl/alu_input_seq_if.sv
// alu_input_seq_if: switch/button inputs, ALU handshake and display outputs of the ALU front-end sequencer
interface alu_input_seq_if;
  logic [3:0] sw_data;
  logic [2:0] sw_op;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] alu_result;
  logic [4:0] alu_flags;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [2:0] sel_out;
  logic [3:0] res_q;
  logic [4:0] flags_q;
  logic [3:0] state_led;
  logic       valid;
  modport master (
    output sw_data, sw_op, btn_enter, btn_clear, alu_result, alu_flags,
    input  a_out, b_out, sel_out, res_q, flags_q, state_led, valid
  );
  modport slave (
    input  sw_data, sw_op, btn_enter, btn_clear, alu_result, alu_flags,
    output a_out, b_out, sel_out, res_q, flags_q, state_led, valid
  );
endinterface

// File: rtl/alu_input_seq.sv
// alu_input_seq: debounced operand/opcode entry sequencer that drives a 4-bit ALU and holds its result for display
module alu_input_seq #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_input_seq_if.slave   bus
);
  typedef enum logic [2:0] {S_A, S_B, S_OP, S_RUN, S_SHOW} state_t;
  // index 0 is ENTER, index 1 is CLEAR
  logic [1:0]       s1_q, s1_d, s2_q, s2_d, stb_q, stb_d, prv_q, prv_d, pls_q, pls_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             enter_p, clear_p;
  state_t           state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       sel_q, sel_d;
  logic [4:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  always_comb begin
    s1_d = {bus.btn_clear, bus.btn_enter};
    s2_d = s1_q;
    stb_d = stb_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (s2_q[k] != stb_q[k]) begin
        if (cnt_q[k] == CNT_W'(DEB_CYCLES - 16'd1)) stb_d[k] = s2_q[k];
        else cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
    prv_d = stb_q;
    pls_d = stb_q & ~prv_q;
  end
  assign enter_p = pls_q[0];
  assign clear_p = pls_q[1];
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sel_d = sel_q;
    res_d = res_q;
    flags_d = flags_q;
    valid_d = valid_q;
    if (clear_p) begin
      state_d = S_A;
      a_d = '0;
      b_d = '0;
      sel_d = '0;
      res_d = '0;
      flags_d = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_A: if (enter_p) begin
          a_d = bus.sw_data;
          state_d = S_B;
        end
        S_B: if (enter_p) begin
          b_d = bus.sw_data;
          state_d = S_OP;
        end
        S_OP: if (enter_p) begin
          sel_d = bus.sw_op;
          valid_d = 1'b0;
          state_d = S_RUN;
        end
        // ALU inputs have been stable since sel registered, so its output is settled here
        S_RUN: begin
          res_d = bus.alu_result;
          flags_d = bus.alu_flags;
          valid_d = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: state_d = enter_p ? S_A : S_SHOW;
        default: state_d = S_A;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      stb_q <= '0;
      prv_q <= '0;
      pls_q <= '0;
      cnt_q <= '{default: '0};
      state_q <= S_A;
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      res_q <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      stb_q <= stb_d;
      prv_q <= prv_d;
      pls_q <= pls_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sel_q <= sel_d;
      res_q <= res_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end
  assign bus.a_out = a_q;
  assign bus.b_out = b_q;
  assign bus.sel_out = sel_q;
  assign bus.res_q = res_q;
  assign bus.flags_q = flags_q;
  assign bus.valid = valid_q;
  assign bus.state_led = {state_q == S_SHOW, state_q == S_OP, state_q == S_B, state_q == S_A};
endmodule

// File: tb/tb_alu_input_seq.sv
// tb_alu_input_seq: table-driven entry sequences plus debounce, clear and reset corner cases
module tb_alu_input_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  alu_input_seq_if bus();
  alu_input_seq #(.DEB_CYCLES(16'd4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] r;
    logic [4:0] f;
  } vec_t;
  vec_t v [4];
  logic [3:0] prev_r;
  logic [4:0] prev_f;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_enter(input int hold);
    bus.btn_enter = 1'b1;
    settle(hold);
    bus.btn_enter = 1'b0;
    settle(12);
  endtask
  task automatic press_clear();
    bus.btn_clear = 1'b1;
    settle(8);
    bus.btn_clear = 1'b0;
    settle(12);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a"}, 32'(bus.a_out), 0);
    chk({tag, "_b"}, 32'(bus.b_out), 0);
    chk({tag, "_sel"}, 32'(bus.sel_out), 0);
    chk({tag, "_res"}, 32'(bus.res_q), 0);
    chk({tag, "_flags"}, 32'(bus.flags_q), 0);
    chk({tag, "_valid"}, 32'(bus.valid), 0);
    chk({tag, "_led"}, 32'(bus.state_led), 32'b0001);
  endtask
  task automatic run_vec(input vec_t t, input int idx);
    int n;
    bus.sw_data = t.a;
    press_enter(8);
    chk($sformatf("v%0d_ledB", idx), 32'(bus.state_led), 32'b0010);
    chk($sformatf("v%0d_a", idx), 32'(bus.a_out), 32'(t.a));
    bus.sw_data = t.b;
    press_enter(8);
    chk($sformatf("v%0d_ledOP", idx), 32'(bus.state_led), 32'b0100);
    chk($sformatf("v%0d_b", idx), 32'(bus.b_out), 32'(t.b));
    bus.sw_data = ~t.b;
    bus.sw_op = t.op;
    bus.alu_result = t.r;
    bus.alu_flags = t.f;
    bus.btn_enter = 1'b1;
    n = 0;
    while (bus.state_led != 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_run_lat", idx), 32'(n), 8);
    chk($sformatf("v%0d_run_valid", idx), 32'(bus.valid), 0);
    chk($sformatf("v%0d_run_res_old", idx), 32'(bus.res_q), 32'(prev_r));
    chk($sformatf("v%0d_sel", idx), 32'(bus.sel_out), 32'(t.op));
    @(negedge clk);
    chk($sformatf("v%0d_ledSHOW", idx), 32'(bus.state_led), 32'b1000);
    chk($sformatf("v%0d_valid", idx), 32'(bus.valid), 1);
    chk($sformatf("v%0d_res", idx), 32'(bus.res_q), 32'(t.r));
    chk($sformatf("v%0d_flags", idx), 32'(bus.flags_q), 32'(t.f));
    bus.btn_enter = 1'b0;
    settle(12);
    bus.sw_data = ~t.a;
    bus.sw_op = ~t.op;
    bus.alu_result = ~t.r;
    settle(3);
    chk($sformatf("v%0d_hold_a", idx), 32'(bus.a_out), 32'(t.a));
    chk($sformatf("v%0d_hold_b", idx), 32'(bus.b_out), 32'(t.b));
    chk($sformatf("v%0d_hold_sel", idx), 32'(bus.sel_out), 32'(t.op));
    chk($sformatf("v%0d_hold_res", idx), 32'(bus.res_q), 32'(t.r));
    prev_r = t.r;
    prev_f = t.f;
  endtask
  initial begin
    v[0] = '{a: 4'h3, b: 4'h5, op: 3'b000, r: 4'h8, f: 5'b10000};
    v[1] = '{a: 4'h2, b: 4'h7, op: 3'b110, r: 4'hB, f: 5'b00010};
    v[2] = '{a: 4'hF, b: 4'hF, op: 3'b111, r: 4'h0, f: 5'b01001};
    v[3] = '{a: 4'hA, b: 4'hC, op: 3'b011, r: 4'h5, f: 5'b00100};
    prev_r = 4'h0;
    prev_f = 5'h0;
    bus.sw_data = 4'h0;
    bus.sw_op = 3'h0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    bus.alu_result = 4'h0;
    bus.alu_flags = 5'h0;
    settle(3);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    settle(3);
    for (int i = 0; i < 4; i++) begin
      run_vec(v[i], i);
      press_enter(8);
      chk($sformatf("v%0d_back_led", i), 32'(bus.state_led), 32'b0001);
      chk($sformatf("v%0d_back_valid", i), 32'(bus.valid), 1);
      chk($sformatf("v%0d_back_res", i), 32'(bus.res_q), 32'(v[i].r));
      chk($sformatf("v%0d_back_flags", i), 32'(bus.flags_q), 32'(prev_f));
    end
    bus.btn_enter = 1'b1;
    settle(2);
    bus.btn_enter = 1'b0;
    settle(20);
    chk("glitch_led", 32'(bus.state_led), 32'b0001);
    bus.sw_data = 4'h9;
    press_enter(100);
    chk("hold_led", 32'(bus.state_led), 32'b0010);
    chk("hold_a", 32'(bus.a_out), 32'h9);
    press_clear();
    chk("clr_a", 32'(bus.a_out), 0);
    chk("clr_led", 32'(bus.state_led), 32'b0001);
    chk("clr_valid", 32'(bus.valid), 0);
    chk("clr_res", 32'(bus.res_q), 0);
    bus.btn_enter = 1'b1;
    bus.btn_clear = 1'b1;
    settle(10);
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    settle(12);
    chk("both_led", 32'(bus.state_led), 32'b0001);
    bus.sw_data = 4'h6;
    press_enter(8);
    chk("rstdeb_pre_a", 32'(bus.a_out), 32'h6);
    bus.btn_enter = 1'b1;
    settle(4);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_deb");
    bus.btn_enter = 1'b0;
    settle(2);
    rst_n = 1'b1;
    settle(20);
    chk("rst_deb_stay", 32'(bus.state_led), 32'b0001);
    press_enter(8);
    chk("rst_deb_fresh", 32'(bus.state_led), 32'b0010);
    press_clear();
    prev_r = 4'h0;
    run_vec(v[0], 4);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_show");
    settle(2);
    rst_n = 1'b1;
    settle(20);
    chk("rst_show_stay", 32'(bus.state_led), 32'b0001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
